// File: rtl/pbkdf2_iter_ctrl_if.sv
// HMAC core request/response channel used by the PBKDF2 iteration controller.
// Request is valid/ready; response is a valid-only single-cycle pulse.
interface pbkdf2_iter_ctrl_if #(
  parameter int unsigned DW = 256
);
  logic          hash_req_valid;
  logic          hash_req_ready;
  logic          hash_req_first;
  logic [DW-1:0] hash_req_data;
  logic          hash_rsp_valid;
  logic [DW-1:0] hash_rsp_data;

  modport master (
    output hash_req_valid,
    output hash_req_first,
    output hash_req_data,
    input  hash_req_ready,
    input  hash_rsp_valid,
    input  hash_rsp_data
  );

  modport slave (
    input  hash_req_valid,
    input  hash_req_first,
    input  hash_req_data,
    output hash_req_ready,
    output hash_rsp_valid,
    output hash_rsp_data
  );
endinterface

// File: rtl/pbkdf2_iter_ctrl.sv
// PBKDF2 iteration controller: chains N HMAC calls and XOR-accumulates
// every iteration output into the derived block T = U1 ^ U2 ^ ... ^ UN.
module pbkdf2_iter_ctrl #(
  parameter int unsigned DW    = 256,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] iter_cnt,
  input  logic             abort,
  pbkdf2_iter_ctrl_if.master hash,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             aborted,
  output logic [CNT_W-1:0] iter_idx,
  output logic [DW-1:0]    result
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } state_t;

  state_t           state;
  logic             first;
  logic [DW-1:0]    u_reg;
  logic [DW-1:0]    acc;
  logic [CNT_W-1:0] remaining;

  // Request outputs decode from registered state only; no input-to-output path.
  assign hash.hash_req_valid = (state == ST_ISSUE);
  assign hash.hash_req_first = (state == ST_ISSUE) && first;
  assign hash.hash_req_data  = ((state == ST_ISSUE) && !first) ? u_reg : '0;
  assign busy                = (state != ST_IDLE);
  assign done                = (state == ST_DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      first     <= 1'b0;
      u_reg     <= '0;
      acc       <= '0;
      remaining <= '0;
      iter_idx  <= '0;
      result    <= '0;
      err       <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      err     <= 1'b0;
      aborted <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (iter_cnt == '0) begin
              err <= 1'b1;
            end else begin
              remaining <= iter_cnt;
              acc       <= '0;
              first     <= 1'b1;
              iter_idx  <= '0;
              state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (abort) begin
            // A request already accepted must have its response absorbed.
            if (hash.hash_req_ready) begin
              state <= ST_DRAIN;
            end else begin
              state   <= ST_IDLE;
              aborted <= 1'b1;
            end
          end else if (hash.hash_req_ready) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            if (hash.hash_rsp_valid) begin
              state   <= ST_IDLE;
              aborted <= 1'b1;
            end else begin
              state <= ST_DRAIN;
            end
          end else if (hash.hash_rsp_valid) begin
            u_reg     <= hash.hash_rsp_data;
            acc       <= acc ^ hash.hash_rsp_data;
            remaining <= remaining - 1'b1;
            iter_idx  <= iter_idx + 1'b1;
            first     <= 1'b0;
            // Leaving at remaining==1 keeps the down-counter from ever wrapping.
            if (remaining == CNT_W'(1)) begin
              result <= acc ^ hash.hash_rsp_data;
              state  <= ST_DONE;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (hash.hash_rsp_valid) begin
            state   <= ST_IDLE;
            aborted <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pbkdf2_iter_ctrl.sv
// Directed and randomized bench for pbkdf2_iter_ctrl with an XOR-chain
// reference model and a lockstep HMAC core model.
module tb_pbkdf2_iter_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] iter_cnt = '0;
  logic          busy, done, err, aborted;
  logic [CW-1:0] iter_idx;
  logic [DW-1:0] result;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] last_result = '0;
  logic [DW-1:0] rsp_tab[$];

  pbkdf2_iter_ctrl_if #(.DW(DW)) hif();

  pbkdf2_iter_ctrl #(.DW(DW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .iter_cnt (iter_cnt),
    .abort    (abort),
    .hash     (hif),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .aborted  (aborted),
    .iter_idx (iter_idx),
    .result   (result)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_aborted"}, aborted, 0);
    check({tag, "_iter_idx"}, iter_idx, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_req_valid"}, hif.hash_req_valid, 0);
    check({tag, "_req_first"}, hif.hash_req_first, 0);
    check({tag, "_req_data"}, hif.hash_req_data, 0);
  endtask

  // One derivation: the model expects req_data to be the previous U and the
  // final result to be the XOR of every response handed back.
  task automatic run(input int unsigned n, input int unsigned stall, input int unsigned dly,
                     input int abort_at, input int unsigned gap, input bit poke);
    logic [DW-1:0] u, u_prev, t;
    u_prev = '0;
    t = '0;
    start = 1'b1;
    iter_cnt = n;
    tick;
    start = 1'b0;
    iter_cnt = $urandom;
    for (int unsigned k = 0; k < n; k++) begin
      check("req_valid", hif.hash_req_valid, 1);
      check("req_first", hif.hash_req_first, k == 0);
      check("req_data", hif.hash_req_data, (k == 0) ? DW'(0) : u_prev);
      for (int unsigned s = 0; s < stall; s++) begin
        if (poke && k == 0 && s == 0) begin
          start = 1'b1;
          iter_cnt = 7;
        end
        tick;
        start = 1'b0;
        check("stall_valid", hif.hash_req_valid, 1);
        check("stall_first", hif.hash_req_first, k == 0);
        check("stall_data", hif.hash_req_data, (k == 0) ? DW'(0) : u_prev);
      end
      hif.hash_req_ready = 1'b1;
      tick;
      hif.hash_req_ready = 1'b0;
      check("wait_valid", hif.hash_req_valid, 0);
      check("wait_busy", busy, 1);
      if (abort_at == int'(k)) begin
        abort = 1'b1;
        tick;
        abort = 1'b0;
        for (int unsigned g = 0; g < gap; g++) begin
          check("drain_busy", busy, 1);
          check("drain_aborted", aborted, 0);
          tick;
        end
        hif.hash_rsp_valid = 1'b1;
        hif.hash_rsp_data = $urandom;
        tick;
        hif.hash_rsp_valid = 1'b0;
        check("abort_pulse", aborted, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, last_result);
        check("abort_iter_idx", iter_idx, k);
        tick;
        check("abort_pulse_end", aborted, 0);
        return;
      end
      for (int unsigned d = 0; d < dly; d++) begin
        check("wait_done", done, 0);
        tick;
      end
      u = (rsp_tab.size() > 0) ? rsp_tab.pop_front() : DW'($urandom);
      hif.hash_rsp_valid = 1'b1;
      hif.hash_rsp_data = u;
      tick;
      hif.hash_rsp_valid = 1'b0;
      hif.hash_rsp_data = $urandom;
      t = t ^ u;
      u_prev = u;
      check("iter_idx", iter_idx, k + 1);
      check("done_timing", done, k == n - 1);
    end
    check("result", result, t);
    check("done_busy", busy, 1);
    last_result = t;
    tick;
    check("done_pulse_end", done, 0);
    check("idle_busy", busy, 0);
    check("result_hold", result, t);
  endtask

  initial begin
    hif.hash_req_ready = 1'b0;
    hif.hash_rsp_valid = 1'b0;
    hif.hash_rsp_data = '0;

    tick;
    tick;
    check_all_zero("reset");
    #3 rstn = 1'b1;
    tick;

    // N=3, always-ready core, response one cycle after each handshake.
    rsp_tab.push_back(32'h11111111);
    rsp_tab.push_back(32'h22222222);
    rsp_tab.push_back(32'h44444444);
    run(3, 0, 0, -1, 0, 1'b0);
    check("n3_result", result, 32'h77777777);
    check("n3_iter_idx", iter_idx, 3);

    // Zero iteration count.
    start = 1'b1;
    iter_cnt = 0;
    tick;
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_result", result, last_result);
    tick;
    check("err_pulse_end", err, 0);
    check("err_busy2", busy, 0);

    // Ready stalled 5 cycles per request.
    run(2, 5, 0, -1, 0, 1'b0);

    // Stray response in IDLE.
    hif.hash_rsp_valid = 1'b1;
    hif.hash_rsp_data = $urandom;
    tick;
    hif.hash_rsp_valid = 1'b0;
    check("stray_busy", busy, 0);
    check("stray_iter_idx", iter_idx, 2);
    check("stray_result", result, last_result);
    check("stray_done", done, 0);
    tick;
    check("stray_busy2", busy, 0);

    // Abort in WAIT of the third request, response 3 cycles later.
    run(4, 0, 0, 2, 2, 1'b0);

    // Abort in ISSUE without ready.
    start = 1'b1;
    iter_cnt = 3;
    tick;
    start = 1'b0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("issue_abort_pulse", aborted, 1);
    check("issue_abort_busy", busy, 0);
    check("issue_abort_valid", hif.hash_req_valid, 0);
    check("issue_abort_result", result, last_result);
    tick;
    check("issue_abort_end", aborted, 0);

    // start pulsed while busy must be ignored.
    run(3, 2, 1, -1, 0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      run($urandom_range(6, 1), $urandom_range(3, 0), $urandom_range(3, 0), -1, 0, 1'b0);
    end

    // Reset mid-run while in ISSUE.
    start = 1'b1;
    iter_cnt = 5;
    tick;
    start = 1'b0;
    check("mid_issue_valid", hif.hash_req_valid, 1);
    #2 rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    #2 rstn = 1'b1;
    tick;
    last_result = '0;
    rsp_tab.push_back(32'hDEADBEEF);
    run(1, 0, 0, -1, 0, 1'b0);
    check("post_reset_result", result, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
